jtag_tap_sampled: RTL
=====================

Name: jtag_tap_sampled

Overview:
- Oversampled IEEE 1149.1 TAP controller. Consumes the bit-bang pins (TCK/TMS/TDI/TRST/SRST) produced by the DPI remote-bit-bang server and drives TDO back to it.
- All JTAG inputs are sampled in the clk_i domain; TCK is treated as data (edge-detected), not used as a clock.
- Provides IDCODE, BYPASS and a USER data register with a parallel capture/update interface, plus a synchronized system-reset request.

Parameters:
- IR_WIDTH, 5, instruction register width (>=2).
- IDCODE_VAL, 32'h1000_563D, IDCODE contents; bit0 must be 1.
- INSTR_IDCODE, 5'h01, IDCODE opcode.
- INSTR_USER, 5'h08, USER opcode; all-ones opcode is BYPASS.
- USER_DR_WIDTH, 16, USER data register width (>=1).

Ports:
- clk_i  in  1  sampling clock.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  1 = process TCK edges; 0 = ignore edges, hold all state.
- jtag_tck_i  in  1  TCK from bit-bang stage (asynchronous).
- jtag_tms_i  in  1  TMS (asynchronous).
- jtag_tdi_i  in  1  TDI (asynchronous).
- jtag_trst_i  in  1  TAP reset, active-high (1 = asserted).
- jtag_srst_i  in  1  system reset request, active-high.
- jtag_tdo_o  out  1  TDO to bit-bang stage.
- tap_state_o  out  4  current TAP state encoding.
- ir_o  out  IR_WIDTH  current latched instruction.
- user_dr_i  in  USER_DR_WIDTH  parallel value captured in CAPTURE_DR when IR=USER.
- user_dr_o  out  USER_DR_WIDTH  value latched in UPDATE_DR when IR=USER.
- user_update_o  out  1  one-clk_i pulse when user_dr_o is updated.
- sys_rst_o  out  1  jtag_srst_i after the 2-FF synchronizer.

Behaviour:
- Reset (rst_ni=0): all synchronizers 0; state=TLR (0xF); ir_o=INSTR_IDCODE; shift regs 0; jtag_tdo_o=0; user_dr_o=0; user_update_o=0; sys_rst_o=0.
- Synchronizers: TCK, TMS, TDI, TRST, SRST each pass through a 2-FF synchronizer. A third TCK flop drives edge detection. rise = sync & ~prev; fall = ~sync & prev. Rise is acted on 3 clk_i cycles after the input change. TCK high and low phases must each be >=4 clk_i cycles; the bit-bang stage meets this by construction.
- enable_i=0: rise/fall are masked. Synchronizers keep running. No state, shift or TDO change.
- Synced TRST=1 (independent of enable_i): state=TLR, ir_o=INSTR_IDCODE, held while asserted. It overrides any simultaneous rise.
- State encoding: TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D. Transitions follow standard 1149.1 using synced TMS at each rise.
- On each rise:
  - First perform the current state's action, then advance state.
  - CAP_IR: IR shift reg <= {0..,01}.
  - SH_IR: IR shift reg <= {tdi, sr[IR_WIDTH-1:1]}.
  - UPD_IR: ir_o <= IR shift reg.
  - CAP_DR: load the selected DR. IDCODE: IDCODE_VAL. USER: user_dr_i. BYPASS or any undefined opcode: 1'b0.
  - SH_DR: shift the selected DR right, TDI into MSB.
  - UPD_DR with ir_o=INSTR_USER: user_dr_o <= USER shift reg; user_update_o=1 for exactly one clk_i.
  - TLR: ir_o <= INSTR_IDCODE.
- On each fall: jtag_tdo_o <= LSB of the active shift reg if state is SH_IR or SH_DR, else 0.
- Five rises with TMS=1 reach TLR from any state.
- tap_state_o and ir_o are registered and reflect the state one clk_i after the rise.

Optional Feature:
- Macro JTAG_TAP_USER_DR_EN.
- Defined: USER register, user_dr_i capture and user_dr_o/user_update_o are implemented as described.
- Undefined: INSTR_USER decodes as BYPASS; user_dr_o is tied 0; user_update_o is tied 0; user_dr_i is unused.

Test Plan:
- Reset, then TMS 0,1,0,0 and 32 TCK cycles shifting (TMS=1 on the last) -> TDO sequence LSB-first equals 32'h1000_563D.
- Load IR=5'h1F via SH_IR, then shift DR with TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (1-bit bypass delay); ir_o=5'h1F after UPD_IR.
- From SH_DR, five TCK cycles with TMS=1 -> tap_state_o=4'hF, ir_o=5'h01.
- jtag_trst_i pulse (6 clk_i) mid SH_IR -> state TLR within 3 clk_i; ir_o=5'h01; a subsequent IDCODE read is correct.
- With the macro defined: IR=5'h08, user_dr_i=16'hA5C3, capture and shift in 16'h1234 -> TDO emits A5C3 LSB-first; user_dr_o=16'h1234; exactly one user_update_o pulse.
- enable_i=0 during 10 TCK cycles -> tap_state_o, ir_o and jtag_tdo_o unchanged; sys_rst_o follows jtag_srst_i after 2 clk_i.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: oversampled IEEE 1149.1 TAP with IDCODE, BYPASS and optional USER DR
// Optional USER register enabled by defining JTAG_TAP_USER_DR_EN.
module jtag_tap_sampled #(
  parameter int unsigned          IR_WIDTH      = 5,
  parameter logic [31:0]          IDCODE_VAL    = 32'h1000_563D,
  parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE  = 5'h01,
  parameter logic [IR_WIDTH-1:0]  INSTR_USER    = 5'h08,
  parameter int unsigned          USER_DR_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     jtag_tck_i,
  input  logic                     jtag_tms_i,
  input  logic                     jtag_tdi_i,
  input  logic                     jtag_trst_i,
  input  logic                     jtag_srst_i,
  output logic                     jtag_tdo_o,
  output logic [3:0]               tap_state_o,
  output logic [IR_WIDTH-1:0]      ir_o,
  input  logic [USER_DR_WIDTH-1:0] user_dr_i,
  output logic [USER_DR_WIDTH-1:0] user_dr_o,
  output logic                     user_update_o,
  output logic                     sys_rst_o
);
  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE,
    SH_IR = 4'hA, EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;
  tap_state_e state_q, state_d, nxt;
  logic [2:0] tck_s;
  logic [1:0] tms_s, tdi_s, trst_s, srst_s;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [31:0] id_sr;
  logic byp_sr, sel_id, sel_user, user_lsb, dr_lsb;
  logic tms, tdi, trst, rise, fall, act;
  assign tms = tms_s[1];
  assign tdi = tdi_s[1];
  assign trst = trst_s[1];
  assign sys_rst_o = srst_s[1];
  assign rise = tck_s[1] & ~tck_s[2] & enable_i;
  assign fall = ~tck_s[1] & tck_s[2] & enable_i;
  assign act = rise & ~trst;
  assign tap_state_o = state_q;
  assign sel_id = ir_o == INSTR_IDCODE;
  assign dr_lsb = sel_id ? id_sr[0] : sel_user ? user_lsb : byp_sr;
  always_comb begin
    nxt = state_q;
    case (state_q)
      TLR:    nxt = tms ? TLR    : RTI;
      RTI:    nxt = tms ? SEL_DR : RTI;
      SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR: nxt = tms ? EX1_DR : SH_DR;
      SH_DR:  nxt = tms ? EX1_DR : SH_DR;
      EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
      PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
      EX2_DR: nxt = tms ? UPD_DR : SH_DR;
      UPD_DR: nxt = tms ? SEL_DR : RTI;
      SEL_IR: nxt = tms ? TLR    : CAP_IR;
      CAP_IR: nxt = tms ? EX1_IR : SH_IR;
      SH_IR:  nxt = tms ? EX1_IR : SH_IR;
      EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
      PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
      EX2_IR: nxt = tms ? UPD_IR : SH_IR;
      UPD_IR: nxt = tms ? SEL_DR : RTI;
    endcase
    state_d = trst ? TLR : act ? nxt : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= TLR;
    else state_q <= state_d;
  // IR also falls back to IDCODE on entry to TLR so the five-TMS escape leaves a known instruction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_s <= '0;
      tms_s <= '0;
      tdi_s <= '0;
      trst_s <= '0;
      srst_s <= '0;
      ir_o <= INSTR_IDCODE;
      ir_sr <= '0;
      id_sr <= '0;
      byp_sr <= 1'b0;
      jtag_tdo_o <= 1'b0;
    end else begin
      tck_s <= {tck_s[1:0], jtag_tck_i};
      tms_s <= {tms_s[0], jtag_tms_i};
      tdi_s <= {tdi_s[0], jtag_tdi_i};
      trst_s <= {trst_s[0], jtag_trst_i};
      srst_s <= {srst_s[0], jtag_srst_i};
      if (trst || (act && (state_q == TLR || nxt == TLR))) ir_o <= INSTR_IDCODE;
      else if (act && state_q == UPD_IR) ir_o <= ir_sr;
      if (act && state_q == CAP_IR) ir_sr <= IR_WIDTH'(1);
      if (act && state_q == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      if (act && state_q == CAP_DR) begin
        id_sr <= IDCODE_VAL;
        byp_sr <= 1'b0;
      end
      if (act && state_q == SH_DR) begin
        id_sr <= {tdi, id_sr[31:1]};
        byp_sr <= tdi;
      end
      if (fall) jtag_tdo_o <= state_q == SH_IR ? ir_sr[0] : state_q == SH_DR ? dr_lsb : 1'b0;
    end
  end
`ifdef JTAG_TAP_USER_DR_EN
  logic [USER_DR_WIDTH-1:0] user_sr;
  assign sel_user = ir_o == INSTR_USER;
  assign user_lsb = user_sr[0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      user_sr <= '0;
      user_dr_o <= '0;
      user_update_o <= 1'b0;
    end else begin
      user_update_o <= act && state_q == UPD_DR && sel_user;
      if (act && state_q == CAP_DR) user_sr <= user_dr_i;
      if (act && state_q == SH_DR) user_sr <= USER_DR_WIDTH'({tdi, user_sr} >> 1);
      if (act && state_q == UPD_DR && sel_user) user_dr_o <= user_sr;
    end
  end
`else
  logic unused_user;
  assign unused_user = ^{user_dr_i, INSTR_USER};
  assign sel_user = 1'b0;
  assign user_lsb = 1'b0;
  assign user_dr_o = '0;
  assign user_update_o = 1'b0;
`endif
endmodule
